// File: rtl/router_pkg.sv
// Shared types and helpers for the 1xN packet router: FSM states, header field
// extraction and counter width calculations.
package router_pkg;

  typedef enum logic [3:0] {
    ST_DECODE,
    ST_WAIT_EMPTY,
    ST_LOAD_FIRST,
    ST_LOAD_DATA,
    ST_FULL,
    ST_LOAD_AFTER_FULL,
    ST_LOAD_PARITY,
    ST_CHECK,
    ST_DROP
  } state_e;

  localparam int unsigned DROP_CNT_W = 16;

  // Down-counter width able to hold TIMEOUT-1.
  function automatic int unsigned tmo_width(input int unsigned timeout);
    return (timeout < 2) ? 1 : $clog2(timeout);
  endfunction

  function automatic logic [31:0] hdr_addr(input logic [31:0] hdr, input int unsigned addr_w);
    return hdr & ((32'd1 << addr_w) - 32'd1);
  endfunction

  function automatic logic [31:0] hdr_len(input logic [31:0] hdr, input int unsigned addr_w);
    return hdr >> addr_w;
  endfunction

endpackage

// File: rtl/router_fifo_p.sv
// Synchronous per-port FIFO with soft reset and registered read data.
// Pointers carry one extra wrap bit to tell full from empty.
module router_fifo_p
  import router_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              soft_reset_i,
  input  logic              wr_en_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              rd_en_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              full_o,
  output logic              empty_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W:0]    wr_ptr_q, rd_ptr_q;
  logic [DATA_W-1:0] rd_data_q;
  logic              do_wr, do_rd, clr;

  assign clr     = reset | soft_reset_i;
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                   (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign do_wr   = wr_en_i & ~full_o;
  assign do_rd   = rd_en_i & ~empty_o;
  assign rd_data_o = rd_data_q;

  always_ff @(posedge clock) begin
    if (clr) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      rd_data_q <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_rd) begin
        rd_data_q <= mem_q[rd_ptr_q[PTR_W-1:0]];
        rd_ptr_q  <= rd_ptr_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (do_wr && !clr) mem_q[wr_ptr_q[PTR_W-1:0]] <= wr_data_i;
  end

endmodule

// File: rtl/router_1xn_top.sv
// 1xN packet router: decodes header, buffers packets per output port, checks
// parity and length, drops illegal packets and flushes stale ports on timeout.
//
// state           | meaning
// ST_DECODE       | idle, waiting for header byte
// ST_WAIT_EMPTY   | target FIFO still holds an older packet
// ST_LOAD_FIRST   | writing latched header into target FIFO
// ST_LOAD_DATA    | accepting payload bytes / parity byte
// ST_FULL         | payload byte parked in hold reg, FIFO full
// ST_LOAD_AFTER_FULL | writing parked byte once space is free
// ST_LOAD_PARITY  | writing received parity byte
// ST_CHECK        | compare parity and length, pulse error on mismatch
// ST_DROP         | swallowing an illegal packet up to its parity byte
module router_1xn_top
  import router_pkg::*;
#(
  parameter int unsigned NUM_PORTS = 3,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned TIMEOUT   = 30
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          pkt_valid,
  input  logic [DATA_W-1:0]             data_in,
  input  logic [NUM_PORTS-1:0]          read_enb,
  output logic [NUM_PORTS*DATA_W-1:0]   data_out,
  output logic [NUM_PORTS-1:0]          valid_out,
  output logic                          busy,
  output logic                          error,
  output logic                          drop,
  output logic [DROP_CNT_W-1:0]         drop_cnt
);

  localparam int unsigned ADDR_W = $clog2(NUM_PORTS);
  localparam int unsigned LEN_W  = DATA_W - ADDR_W;
  localparam int unsigned TMO_W  = tmo_width(TIMEOUT);
  localparam logic [TMO_W-1:0] TMO_RELOAD = TMO_W'(TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0] hdr_q, hdr_d, parity_q, parity_d, hold_q, hold_d;
  logic              drop_q, drop_d;
  logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  logic [NUM_PORTS-1:0] fifo_full, fifo_empty, flush, fifo_wr;
  logic                 wr_en;
  logic [DATA_W-1:0]    wr_data;
  logic [ADDR_W-1:0]    in_addr;
  logic [LEN_W-1:0]     in_len;
  logic                 in_legal, tgt_full, tgt_empty, tgt_flush, writing;

  assign in_addr   = ADDR_W'(hdr_addr(32'(data_in), ADDR_W));
  assign in_len    = LEN_W'(hdr_len(32'(data_in), ADDR_W));
  assign in_legal  = (32'(in_addr) < NUM_PORTS) && (in_len != '0);
  assign tgt_full  = fifo_full[addr_q];
  assign tgt_empty = fifo_empty[addr_q];
  assign tgt_flush = flush[addr_q];
  assign writing   = state_q inside {ST_LOAD_FIRST, ST_LOAD_DATA, ST_FULL,
                                     ST_LOAD_AFTER_FULL, ST_LOAD_PARITY};

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    hdr_d      = hdr_q;
    parity_d   = parity_q;
    hold_d     = hold_q;
    drop_d     = 1'b0;
    drop_cnt_d = drop_cnt_q;
    wr_en      = 1'b0;
    wr_data    = hdr_q;
    case (state_q)
      ST_DECODE: if (pkt_valid) begin
        addr_d   = in_addr;
        len_d    = in_len;
        hdr_d    = data_in;
        parity_d = data_in;
        cnt_d    = '0;
        if (!in_legal) begin
          state_d = ST_DROP;
          drop_d  = 1'b1;
          if (drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + 1'b1;
        end else if (fifo_empty[in_addr]) begin
          state_d = ST_LOAD_FIRST;
        end else begin
          state_d = ST_WAIT_EMPTY;
        end
      end
      ST_WAIT_EMPTY: if (tgt_empty) state_d = ST_LOAD_FIRST;
      ST_LOAD_FIRST: begin
        wr_en   = 1'b1;
        state_d = ST_LOAD_DATA;
      end
      ST_LOAD_DATA: begin
        if (pkt_valid) begin
          parity_d = parity_q ^ data_in;
          if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
          if (!tgt_full) begin
            wr_en   = 1'b1;
            wr_data = data_in;
          end else begin
            hold_d  = data_in;
            state_d = ST_FULL;
          end
        end else begin
          hold_d  = data_in;
          state_d = ST_LOAD_PARITY;
        end
      end
      ST_FULL: if (!tgt_full) state_d = ST_LOAD_AFTER_FULL;
      ST_LOAD_AFTER_FULL: begin
        wr_en   = 1'b1;
        wr_data = hold_q;
        state_d = ST_LOAD_DATA;
      end
      ST_LOAD_PARITY: if (!tgt_full) begin
        wr_en   = 1'b1;
        wr_data = hold_q;
        state_d = ST_CHECK;
      end
      ST_CHECK: state_d = ST_DECODE;
      ST_DROP:  if (!pkt_valid) state_d = ST_DECODE;
      default:  state_d = ST_DECODE;
    endcase
    // A timeout flush of the port being written abandons the packet silently.
    if (writing && tgt_flush) begin
      state_d = ST_DECODE;
      wr_en   = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_DECODE;
      addr_q     <= '0;
      len_q      <= '0;
      cnt_q      <= '0;
      hdr_q      <= '0;
      parity_q   <= '0;
      hold_q     <= '0;
      drop_q     <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      hdr_q      <= hdr_d;
      parity_q   <= parity_d;
      hold_q     <= hold_d;
      drop_q     <= drop_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign busy     = !(state_q inside {ST_DECODE, ST_LOAD_DATA, ST_DROP});
  assign error    = (state_q == ST_CHECK) &&
                    ((parity_q != hold_q) || (cnt_q != {1'b0, len_q}));
  assign drop     = drop_q;
  assign drop_cnt = drop_cnt_q;

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    logic [TMO_W-1:0] tmo_q;
    logic             stall;

    assign valid_out[p] = ~fifo_empty[p];
    assign stall        = valid_out[p] & ~read_enb[p];
    assign flush[p]     = stall && (tmo_q == '0);
    assign fifo_wr[p]   = wr_en && (addr_q == ADDR_W'(p));

    always_ff @(posedge clock) begin
      if (reset || !stall || tmo_q == '0) tmo_q <= TMO_RELOAD;
      else                                tmo_q <= tmo_q - 1'b1;
    end

    router_fifo_p #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
      .clock        (clock),
      .reset        (reset),
      .soft_reset_i (flush[p]),
      .wr_en_i      (fifo_wr[p]),
      .wr_data_i    (wr_data),
      .rd_en_i      (read_enb[p]),
      .rd_data_o    (data_out[p*DATA_W +: DATA_W]),
      .full_o       (fifo_full[p]),
      .empty_o      (fifo_empty[p])
    );
  end

endmodule

// File: tb/tb_router_1xn_top.sv
// Directed bench for router_1xn_top (3 ports, 8-bit, depth 16, timeout 30).
module tb_router_1xn_top;

  logic        clock = 1'b0;
  logic        reset;
  logic        pkt_valid;
  logic [7:0]  data_in;
  logic [2:0]  read_enb;
  logic [23:0] data_out;
  logic [2:0]  valid_out;
  logic        busy, error, drop;
  logic [15:0] drop_cnt;

  int n_checks = 0;
  int n_errors = 0;
  int err_seen = 0;
  int drop_seen = 0;
  logic [7:0] pkt   [0:31];
  logic [7:0] exp_b [0:31];

  router_1xn_top #(.NUM_PORTS(3), .DATA_W(8), .DEPTH(16), .TIMEOUT(30)) dut (
    .clock     (clock),
    .reset     (reset),
    .pkt_valid (pkt_valid),
    .data_in   (data_in),
    .read_enb  (read_enb),
    .data_out  (data_out),
    .valid_out (valid_out),
    .busy      (busy),
    .error     (error),
    .drop      (drop),
    .drop_cnt  (drop_cnt)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (error) err_seen++;
    if (drop)  drop_seen++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present one byte and return right after the edge that accepts it.
  task automatic send_byte(input logic [7:0] b, input logic v);
    int guard = 0;
    @(negedge clock);
    data_in   = b;
    pkt_valid = v;
    while (busy && guard < 200) begin
      @(negedge clock);
      guard++;
    end
    if (guard >= 200) check_eq("busy_wait_expired", 1, 0);
    @(posedge clock);
  endtask

  task automatic send_pkt(input int n);
    for (int i = 0; i < n; i++) send_byte(pkt[i], (i != n - 1));
    pkt_valid = 1'b0;
  endtask

  task automatic read_check(input int p, input int n, input string tag);
    int got = 0;
    int guard = 0;
    logic pv;
    @(negedge clock);
    read_enb[p] = 1'b1;
    pv = valid_out[p];
    while (got < n && guard < 300) begin
      @(negedge clock);
      guard++;
      if (pv) begin
        check_eq($sformatf("%s_byte%0d", tag, got), data_out[p*8 +: 8], exp_b[got]);
        got++;
      end
      pv = valid_out[p];
    end
    read_enb[p] = 1'b0;
    check_eq({tag, "_count"}, got, n);
  endtask

  initial begin
    int e0, d0;
    reset = 1'b1; pkt_valid = 1'b0; data_in = '0; read_enb = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check_eq("rst_valid", valid_out, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_error", error, 0);
    check_eq("rst_drop", drop, 0);
    check_eq("rst_dropcnt", drop_cnt, 0);
    check_eq("rst_dout", data_out, 0);
    reset = 1'b0;

    // 1: good packet to port 1
    e0 = err_seen;
    pkt[0] = 8'h0D; pkt[1] = 8'h11; pkt[2] = 8'h22; pkt[3] = 8'h33; pkt[4] = 8'h0D;
    send_pkt(5);
    repeat (3) @(negedge clock);
    check_eq("t1_valid", valid_out, 3'b010);
    check_eq("t1_noerr", err_seen - e0, 0);
    exp_b[0] = 8'h0D; exp_b[1] = 8'h11; exp_b[2] = 8'h22; exp_b[3] = 8'h33; exp_b[4] = 8'h0D;
    read_check(1, 5, "t1_rd");
    check_eq("t1_empty", valid_out, 0);

    // 2: bad parity -> one-cycle error in CHECK, packet still stored
    e0 = err_seen;
    pkt[4] = 8'hF2;
    send_pkt(5);
    @(negedge clock); check_eq("t2_err_ldpar", error, 0);
    @(negedge clock); check_eq("t2_err_check", error, 1);
    @(negedge clock); check_eq("t2_err_after", error, 0);
    check_eq("t2_err_cycles", err_seen - e0, 1);
    exp_b[4] = 8'hF2;
    read_check(1, 5, "t2_rd");

    // 3: illegal address dropped, then a legal packet
    d0 = drop_seen;
    pkt[0] = 8'h0F; pkt[1] = 8'hAA; pkt[2] = 8'h55;
    send_pkt(3);
    repeat (2) @(negedge clock);
    check_eq("t3_drop_pulse", drop_seen - d0, 1);
    check_eq("t3_dropcnt", drop_cnt, 1);
    check_eq("t3_novalid", valid_out, 0);
    pkt[0] = 8'h09; pkt[1] = 8'hAA; pkt[2] = 8'hBB; pkt[3] = 8'h18;
    send_pkt(4);
    repeat (3) @(negedge clock);
    check_eq("t3_valid", valid_out, 3'b010);
    exp_b[0] = 8'h09; exp_b[1] = 8'hAA; exp_b[2] = 8'hBB; exp_b[3] = 8'h18;
    read_check(1, 4, "t3_rd");

    // 4: len 15 to port 0 fills the FIFO, then drain 17 bytes
    e0 = err_seen;
    pkt[0] = 8'h3C;
    for (int i = 1; i <= 15; i++) pkt[i] = 8'(i);
    pkt[16] = 8'h3C;
    send_pkt(17);
    @(negedge clock); check_eq("t4_busy_full", busy, 1);
    repeat (2) @(negedge clock);
    check_eq("t4_busy_held", busy, 1);
    check_eq("t4_valid", valid_out, 3'b001);
    for (int i = 0; i < 17; i++) exp_b[i] = pkt[i];
    read_check(0, 17, "t4_rd");
    repeat (3) @(negedge clock);
    check_eq("t4_noerr", err_seen - e0, 0);
    check_eq("t4_idle", busy, 0);

    // 5: port 2 left unread after one byte -> flushed by timeout
    pkt[0] = 8'h06; pkt[1] = 8'h77; pkt[2] = 8'h71;
    send_pkt(3);
    repeat (3) @(negedge clock);
    read_enb[2] = 1'b1;
    @(negedge clock);
    read_enb[2] = 1'b0;
    check_eq("t5_first", data_out[23:16], 8'h06);
    repeat (20) @(negedge clock);
    check_eq("t5_valid_pre", valid_out, 3'b100);
    check_eq("t5_dout_pre", data_out[23:16], 8'h06);
    repeat (12) @(negedge clock);
    check_eq("t5_valid_post", valid_out, 0);
    check_eq("t5_dout_post", data_out[23:16], 8'h00);

    // 6: reset mid-payload
    send_byte(8'h0D, 1'b1);
    send_byte(8'h11, 1'b1);
    @(negedge clock);
    check_eq("t6_valid_pre", valid_out, 3'b010);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0; pkt_valid = 1'b0;
    check_eq("t6_busy", busy, 0);
    check_eq("t6_valid", valid_out, 0);
    check_eq("t6_dropcnt", drop_cnt, 0);
    pkt[0] = 8'h05; pkt[1] = 8'h44; pkt[2] = 8'h41;
    send_pkt(3);
    repeat (3) @(negedge clock);
    check_eq("t6_valid_new", valid_out, 3'b010);
    exp_b[0] = 8'h05; exp_b[1] = 8'h44; exp_b[2] = 8'h41;
    read_check(1, 3, "t6_rd");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
